pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 tb/tb_pipe_stage_reg.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register; control payload is cleared on flush.
// Optional skid buffer: define PIPE_STAGE_REG_SKID_EN.
//   Default build: one entry. ready_o = ~valid_o | ready_i (combinational).
//   Skid build:    two entries (head + skid). ready_o is registered and does not depend on ready_i.
// Ports:
//   clk, rst_n (asynchronous, active-low), flush_i
//   upstream   : valid_i, ready_o, data_i[DATA_WIDTH], ctrl_i[CTRL_WIDTH]
//   downstream : valid_o, ready_i, data_o[DATA_WIDTH], ctrl_o[CTRL_WIDTH]
//   occupancy_o[2] : number of held entries
module pipe_stage_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [1:0]            occupancy_o
);
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic                  in_xfer;
  logic                  out_xfer;
  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign ctrl_o   = ctrl_q;
  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_q & ready_i;
`ifdef PIPE_STAGE_REG_SKID_EN
  // The state encoding equals the number of held entries.
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_e;
  state_e                state_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] skid_data_q;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q;
  assign ready_o     = ready_q;
  assign occupancy_o = state_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      data_q      <= '0;
      ctrl_q      <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush_i) begin
      state_q     <= EMPTY;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      ctrl_q      <= '0;
      skid_ctrl_q <= '0;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) begin
          state_q <= FULL;
          valid_q <= 1'b1;
          data_q  <= data_i;
          ctrl_q  <= ctrl_i;
        end
        FULL: if (in_xfer && out_xfer) begin
          data_q <= data_i;
          ctrl_q <= ctrl_i;
        end else if (in_xfer) begin
          // Downstream stalled: park the new entry and stop accepting.
          state_q     <= SKID;
          ready_q     <= 1'b0;
          skid_data_q <= data_i;
          skid_ctrl_q <= ctrl_i;
        end else if (out_xfer) begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
        end
        SKID: if (out_xfer) begin
          state_q <= FULL;
          ready_q <= 1'b1;
          data_q  <= skid_data_q;
          ctrl_q  <= skid_ctrl_q;
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  // A retiring head frees the slot in the same cycle, so back-to-back throughput is kept.
  assign ready_o     = ~valid_q | ready_i;
  assign occupancy_o = {1'b0, valid_q};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      ctrl_q  <= ctrl_i;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of pipe_stage_reg against a queue model.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 6;
`ifdef PIPE_STAGE_REG_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [CW-1:0] ctrl_i = '0;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic [CW-1:0] ctrl_o;
  logic [1:0]    occupancy_o;
  typedef struct packed {logic [CW-1:0] c; logic [DW-1:0] d;} ent_t;
  ent_t q[$];
  bit   czero = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .ctrl_i(ctrl_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .ctrl_o(ctrl_o), .occupancy_o(occupancy_o)
  );
  always #5 clk = ~clk;
  function automatic bit m_ready();
`ifdef PIPE_STAGE_REG_SKID_EN
    return q.size() < 2;
`else
    return q.size() == 0 || ready_i;
`endif
  endfunction
  task automatic m_reset();
    q.delete();
    czero = 1'b1;
  endtask
  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c, input bit r, input bit f);
    valid_i = v;
    data_i  = d;
    ctrl_i  = c;
    ready_i = r;
    flush_i = f;
    #1;
  endtask
  task automatic tick();
    bit   in_x;
    bit   out_x;
    ent_t e;
    in_x  = valid_i && m_ready();
    out_x = q.size() > 0 && ready_i;
    e     = '{c: ctrl_i, d: data_i};
    @(posedge clk);
    if (flush_i) begin
      q.delete();
      czero = 1'b1;
    end else begin
      if (out_x) void'(q.pop_front());
      if (in_x) begin
        q.push_back(e);
        czero = 1'b0;
      end
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    #1 rst_n = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if ({valid_o, ready_o, occupancy_o, ctrl_o} !== {1'b0, 1'b1, 2'd0, 6'd0}) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b r=%b occ=%0d ctrl=%h expected v=0 r=1 occ=0 ctrl=00", valid_o, ready_o, occupancy_o, ctrl_o);
    end
    n_cmp++;
    if (data_o !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h expected 0", data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_stream();
    for (int i = 1; i <= 9; i++) begin
      drive(i <= 8, DW'(i), CW'(i), 1'b1, 1'b0);
      if (i > 1) begin
        n_cmp++;
        if ({valid_o, data_o, occupancy_o} !== {1'b1, DW'(i - 1), 2'd1}) begin
          n_err++;
          $display("FAIL stream[%0d]: got v=%b data=%h occ=%0d expected v=1 data=%h occ=1", i, valid_o, data_o, occupancy_o, i - 1);
        end
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_cmp++;
    if ({valid_o, occupancy_o} !== {1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL stream_drained: got v=%b occ=%0d expected v=0 occ=0", valid_o, occupancy_o);
    end
  endtask
  task automatic test_backpressure();
`ifdef PIPE_STAGE_REG_SKID_EN
    drive(1'b1, 32'hA, 6'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hB, 6'd2, 1'b0, 1'b0);
    n_cmp++;
    if ({occupancy_o, ready_o, data_o} !== {2'd1, 1'b1, 32'hA}) begin
      n_err++;
      $display("FAIL bp_one: got occ=%0d r=%b data=%h expected occ=1 r=1 data=a", occupancy_o, ready_o, data_o);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'hC, 6'd3, 1'b0, 1'b0);
      n_cmp++;
      if ({occupancy_o, ready_o, valid_o, data_o, ctrl_o} !== {2'd2, 1'b0, 1'b1, 32'hA, 6'd1}) begin
        n_err++;
        $display("FAIL bp_skid[%0d]: got occ=%0d r=%b v=%b data=%h ctrl=%h expected occ=2 r=0 v=1 data=a ctrl=01", k, occupancy_o, ready_o, valid_o, data_o, ctrl_o);
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if ({valid_o, data_o, ctrl_o, occupancy_o, ready_o} !== {1'b1, 32'hB, 6'd2, 2'd1, 1'b1}) begin
      n_err++;
      $display("FAIL bp_second: got v=%b data=%h ctrl=%h occ=%0d r=%b expected v=1 data=b ctrl=02 occ=1 r=1", valid_o, data_o, ctrl_o, occupancy_o, ready_o);
    end
    tick();
    n_cmp++;
    if ({valid_o, occupancy_o} !== {1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL bp_drained: got v=%b occ=%0d expected v=0 occ=0", valid_o, occupancy_o);
    end
`else
    drive(1'b1, 32'hA, 6'd1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_cmp++;
    if ({valid_o, ready_o, data_o} !== {1'b1, 1'b0, 32'hA}) begin
      n_err++;
      $display("FAIL bp_stall: got v=%b r=%b data=%h expected v=1 r=0 data=a", valid_o, ready_o, data_o);
    end
    drive(1'b1, 32'hB, 6'd2, 1'b1, 1'b0);
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got r=%b expected r=1", ready_o);
    end
    tick();
    drive(1'b1, 32'hC, 6'd3, 1'b1, 1'b0);
    n_cmp++;
    if ({valid_o, data_o, ready_o} !== {1'b1, 32'hB, 1'b1}) begin
      n_err++;
      $display("FAIL bp_b2b_b: got v=%b data=%h r=%b expected v=1 data=b r=1", valid_o, data_o, ready_o);
    end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if ({valid_o, data_o} !== {1'b1, 32'hC}) begin
      n_err++;
      $display("FAIL bp_b2b_c: got v=%b data=%h expected v=1 data=c", valid_o, data_o);
    end
    tick();
`endif
  endtask
  task automatic test_flush();
    for (int k = 0; k < CAP; k++) begin
      drive(1'b1, DW'(32'h10 + k), 6'h3F, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hEE, 6'h3F, CAP == 1, 1'b1);
    n_cmp++;
    if (occupancy_o !== 2'(CAP)) begin
      n_err++;
      $display("FAIL flush_fill: got occ=%0d expected %0d", occupancy_o, CAP);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if ({valid_o, ctrl_o, occupancy_o, ready_o} !== {1'b0, 6'd0, 2'd0, 1'b1}) begin
        n_err++;
        $display("FAIL flush_empty[%0d]: got v=%b ctrl=%h occ=%0d r=%b expected v=0 ctrl=00 occ=0 r=1", k, valid_o, ctrl_o, occupancy_o, ready_o);
      end
      tick();
    end
  endtask
  task automatic test_async_reset();
    drive(1'b1, 32'h55, 6'h2A, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_cmp++;
    if ({valid_o, occupancy_o} !== {1'b1, 2'd1}) begin
      n_err++;
      $display("FAIL areset_pre: got v=%b occ=%0d expected v=1 occ=1", valid_o, occupancy_o);
    end
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if ({valid_o, ctrl_o, occupancy_o, ready_o, data_o} !== {1'b0, 6'd0, 2'd0, 1'b1, 32'd0}) begin
      n_err++;
      $display("FAIL areset_now: got v=%b ctrl=%h occ=%0d r=%b data=%h expected v=0 ctrl=00 occ=0 r=1 data=0", valid_o, ctrl_o, occupancy_o, ready_o, data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h77, 6'h15, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if ({valid_o, data_o, ctrl_o} !== {1'b1, 32'h77, 6'h15}) begin
      n_err++;
      $display("FAIL areset_first: got v=%b data=%h ctrl=%h expected v=1 data=77 ctrl=15", valid_o, data_o, ctrl_o);
    end
    tick();
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom % 4 != 0, DW'($urandom), CW'($urandom), $urandom % 3 != 0, $urandom % 25 == 0);
      n_cmp++;
      if ({valid_o, ready_o, occupancy_o} !== {q.size() != 0, m_ready(), 2'(q.size())}) begin
        n_err++;
        $display("FAIL rand_hs[%0d]: got v=%b r=%b occ=%0d expected v=%b r=%b occ=%0d", i, valid_o, ready_o, occupancy_o, q.size() != 0, m_ready(), q.size());
      end
      if (q.size() != 0) begin
        n_cmp++;
        if ({ctrl_o, data_o} !== q[0]) begin
          n_err++;
          $display("FAIL rand_head[%0d]: got ctrl=%h data=%h expected ctrl=%h data=%h", i, ctrl_o, data_o, q[0].c, q[0].d);
        end
      end else if (czero) begin
        n_cmp++;
        if (ctrl_o !== '0) begin
          n_err++;
          $display("FAIL rand_ctrl_clear[%0d]: got ctrl=%h expected 00", i, ctrl_o);
        end
      end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
